mips_register_mem: RTL and testbench
====================================

# mips_register_mem

32-entry × 32-bit general-purpose register file for the MIPS datapath. It provides two combinational read ports and one synchronous write port. It sits between instruction decode, which supplies the rs/rt read addresses, and writeback, which supplies the rd/rt destination and the result data. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers (must equal 2**ADDR_W)

Ports:
- clk  input  1  single clock; all state updates occur on the rising edge
- resetN  input  1  asynchronous, active-high reset; asserted when 1 despite the name
- regWrite  input  1  write enable
- rdReg1  input  ADDR_W  read port 1 address
- rdReg2  input  ADDR_W  read port 2 address
- wrReg  input  ADDR_W  write address
- wrData  input  DATA_W  write data
- data1  output  DATA_W  contents of register rdReg1
- data2  output  DATA_W  contents of register rdReg2

## Operation
- Storage: NUM_REGS registers, each DATA_W bits wide.
- Reset: while resetN=1, all registers are forced to 0 immediately, without waiting for a clock edge. Reset takes priority over any write.
- Write: on a rising clk edge with resetN=0, regWrite=1 and wrReg≠0, register[wrReg] takes the value of wrData.
- With regWrite=0, nothing changes.
- Writes to register 0 are discarded. Register 0 always reads 0.
- Read: data1 = register[rdReg1] and data2 = register[rdReg2].
  - Both are purely combinational from the address inputs and the stored state.
  - Both ports are independent; both may address the same register.
- No internal write-to-read bypass. When a read address equals wrReg during a write cycle, the read port shows the old value until the clock edge, then the new value.
- No X-propagation from unwritten registers. Every register is defined from reset onward.

## Timing
- Read latency: 0 cycles (combinational). data1 and data2 follow rdReg1/rdReg2 changes within the same cycle.
- Write latency: 1 edge. The new value is visible on the read ports immediately after the rising edge that samples regWrite=1.
- Reset assert: asynchronous. data1 and data2 become 0 without a clock edge.
- Reset deassert: the first write can occur on the first rising edge after resetN falls to 0.
- Reset during an active write: the write is lost; the target register stays 0.
- Reset values: data1=0, data2=0, all registers 0.
- There is no handshake and no stall. A write is accepted every cycle that regWrite=1.

## Structure
- Shared package (mips_pkg): DATA_W, ADDR_W, NUM_REGS and the constant REG_ZERO=5'd0. It also holds the typedefs reg_addr_t (logic [ADDR_W-1:0]) and word_t (logic [DATA_W-1:0]) for reuse by decode and writeback.
- Single module, no sub-modules. The register array, write logic and two read multiplexers are all inline.
- Implement register 0 as a constant rather than storage, or force its reads to 0.

## Test plan
- Reset: drive resetN=1 with any addresses, no clock edge → data1=0 and data2=0 for rdReg1=0 and rdReg2=1. Also sweep all 32 addresses → all read 0.
- Basic write/read: resetN=0, regWrite=1, wrReg=1, wrData=32'h0000_0101, one clock edge → data2 (rdReg2=1) = 32'h0000_0101. Set regWrite=0 for the next edge with wrData=32'hFFFF_FFFF → data2 stays 32'h0000_0101.
- Zero register: regWrite=1, wrReg=0, wrData=32'h0000_0101, clock edge → data1 (rdReg1=0) = 0.
- Same-cycle read of the write target: rdReg1=wrReg=5 (old value 0), write 32'hDEAD_BEEF → data1=0 before the edge, 32'hDEAD_BEEF after it. Set rdReg2=5 as well → both ports agree.
- Full sweep: write value 32'hA5A5_0000+i to registers 1..31 in turn, then read every pair (i, 31−i) → exact values, with register 0 reading 0.
- Asynchronous reset mid-operation: with registers loaded, assert resetN=1 between clock edges while regWrite=1 → all reads go to 0 immediately. The pending write does not occur.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register file geometry and the
// address/word types used by decode, the register file and writeback.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Architectural zero register ($zero).
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/mips_register_mem.sv
// MIPS general-purpose register file: NUM_REGS x DATA_W, two combinational
// read ports and one synchronous write port. Register 0 reads as zero and
// ignores writes. There is no write-to-read bypass.
//
// Ports:
//   clk      - rising-edge clock for writes
//   resetN   - asynchronous reset, active HIGH despite the name
//   regWrite - write enable
//   rdReg1   - read port 1 address  -> data1
//   rdReg2   - read port 2 address  -> data2
//   wrReg    - write address
//   wrData   - write data
//   data1    - combinational contents of register rdReg1
//   data2    - combinational contents of register rdReg2
module mips_register_mem #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] rdReg1,
  input  logic [ADDR_W-1:0] rdReg2,
  input  logic [ADDR_W-1:0] wrReg,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2
);

  import mips_pkg::*;

  // Zero-register address at this instance's address width.
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Register 0 has no storage; the array starts at index 1.
  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];

  logic write_en;

  // Writes addressed to register 0 are dropped here.
  assign write_en = regWrite && (wrReg != ZERO_ADDR);

  // Next-state: hold every register except the addressed write target.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (write_en && (wrReg == ADDR_W'(i))) begin
        regs_d[i] = wrData;
      end
    end
  end

  // Storage; reset clears everything immediately and beats any write.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read muxes: default of zero covers register 0.
  always_comb begin
    data1 = '0;
    data2 = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (rdReg1 == ADDR_W'(i)) begin
        data1 = regs_q[i];
      end
      if (rdReg2 == ADDR_W'(i)) begin
        data2 = regs_q[i];
      end
    end
  end

endmodule : mips_register_mem

// File: tb/tb_mips_register_mem.sv
// Self-checking bench for mips_register_mem: directed steps from the test
// plan followed by randomized traffic against an array reference model.
module tb_mips_register_mem;

  logic        clk;
  logic        resetN;
  logic        regWrite;
  logic [4:0]  rdReg1;
  logic [4:0]  rdReg2;
  logic [4:0]  wrReg;
  logic [31:0] wrData;
  logic [31:0] data1;
  logic [31:0] data2;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model: architectural register contents.
  logic [31:0] model [32];

  mips_register_mem #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .NUM_REGS(32)
  ) dut (
    .clk     (clk),
    .resetN  (resetN),
    .regWrite(regWrite),
    .rdReg1  (rdReg1),
    .rdReg2  (rdReg2),
    .wrReg   (wrReg),
    .wrData  (wrData),
    .data1   (data1),
    .data2   (data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Architectural write rule: enabled, non-zero destination.
  task automatic model_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    if (we && a != 5'd0) model[a] = d;
  endtask

  // Present a write, clock it in, then update the model.
  task automatic do_write(input logic we, input logic [4:0] a, input logic [31:0] d);
    regWrite = we;
    wrReg    = a;
    wrData   = d;
    @(posedge clk);
    #1;
    model_write(we, a, d);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetN   = 1'b0;
    regWrite = 1'b0;
    rdReg1   = 5'd0;
    rdReg2   = 5'd1;
    wrReg    = 5'd0;
    wrData   = 32'h0;

    // Reset with no clock edge yet.
    #1 resetN = 1'b1;
    model_reset();
    #1;
    check("reset_data1_r0", data1, 32'h0);
    check("reset_data2_r1", data2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rdReg1 = 5'(i);
      #0.5;
      check($sformatf("reset_sweep_r%0d", i), data1, model[i]);
    end

    // Leave reset between edges.
    @(negedge clk);
    resetN = 1'b0;

    // Basic write / hold.
    rdReg2 = 5'd1;
    do_write(1'b1, 5'd1, 32'h0000_0101);
    check("basic_write_r1", data2, 32'h0000_0101);
    do_write(1'b0, 5'd1, 32'hFFFF_FFFF);
    check("no_write_hold_r1", data2, 32'h0000_0101);

    // Zero register ignores writes.
    rdReg1 = 5'd0;
    do_write(1'b1, 5'd0, 32'h0000_0101);
    check("zero_reg_write", data1, 32'h0);

    // Read of the write target: old value before the edge, new after.
    rdReg1   = 5'd5;
    regWrite = 1'b1;
    wrReg    = 5'd5;
    wrData   = 32'hDEAD_BEEF;
    #1;
    check("same_cycle_before_edge", data1, model[5]);
    @(posedge clk);
    #1;
    model_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    check("same_cycle_after_edge", data1, 32'hDEAD_BEEF);
    rdReg2   = 5'd5;
    regWrite = 1'b0;
    #1;
    check("both_ports_same_reg", data2, data1);
    check("both_ports_value", data2, 32'hDEAD_BEEF);

    // Full sweep of all writable registers, read back as mirrored pairs.
    for (int i = 1; i < 32; i++) begin
      do_write(1'b1, 5'(i), 32'hA5A5_0000 + 32'(i));
    end
    regWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rdReg1 = 5'(i);
      rdReg2 = 5'(31 - i);
      #0.5;
      check($sformatf("sweep_p1_r%0d", i), data1, (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i));
      check($sformatf("sweep_p2_r%0d", 31 - i), data2, model[31 - i]);
    end

    // Randomized traffic: reads checked before each edge against pre-edge state.
    for (int n = 0; n < 300; n++) begin
      regWrite = 1'($urandom_range(0, 1));
      wrReg    = 5'($urandom_range(0, 31));
      wrData   = $urandom;
      rdReg1   = 5'($urandom_range(0, 31));
      rdReg2   = ($urandom_range(0, 3) == 0) ? wrReg : 5'($urandom_range(0, 31));
      #1;
      check("rand_data1", data1, model[rdReg1]);
      check("rand_data2", data2, model[rdReg2]);
      @(posedge clk);
      #1;
      model_write(regWrite, wrReg, wrData);
      check("rand_post_edge_data2", data2, model[rdReg2]);
    end

    // Asynchronous reset between edges with a write pending.
    regWrite = 1'b1;
    wrReg    = 5'd7;
    wrData   = 32'h1234_5678;
    rdReg1   = 5'd7;
    rdReg2   = 5'd31;
    #2;
    resetN = 1'b1;
    model_reset();
    #0.5;
    check("async_reset_data1", data1, 32'h0);
    check("async_reset_data2", data2, 32'h0);
    @(posedge clk);
    #1;
    check("reset_blocks_write_r7", data1, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rdReg2 = 5'(i);
      #0.25;
      check($sformatf("post_reset_sweep_r%0d", i), data2, model[i]);
    end

    // First write right after reset release.
    @(negedge clk);
    resetN = 1'b0;
    rdReg1 = 5'd3;
    do_write(1'b1, 5'd3, 32'hCAFE_F00D);
    check("first_write_after_reset", data1, 32'hCAFE_F00D);
    check("first_write_model", data1, model[3]);
    regWrite = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mips_register_mem
